// File: rtl/mul_operand_sequencer.sv
// Multiplier-side operand sequencer: reads X (bank A) and Y (bank B), hands them to the field
// multiplier, writes the product to bank C. Define MUL_SEQ_TIMEOUT_EN for the product-wait timeout.
module mul_operand_sequencer #(
    parameter int DATA        = 256,
    parameter int ADDR        = 2,
    parameter int RD_LAT      = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [ADDR-1:0] src_x_addr,
    input  logic [ADDR-1:0] src_y_addr,
    input  logic [ADDR-1:0] dst_addr,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            b_w_A,
    output logic            b_w_B,
    output logic [ADDR-1:0] b_adbus_A,
    output logic [ADDR-1:0] b_adbus_B,
    output logic [DATA-1:0] b_data_in_A,
    output logic [DATA-1:0] b_data_in_B,
    input  logic [DATA-1:0] b_data_out_A,
    input  logic [DATA-1:0] b_data_out_B,
    output logic            b_w_C,
    output logic [ADDR-1:0] b_adbus_C,
    output logic [DATA-1:0] b_data_in_C,
    output logic [DATA-1:0] mul_x,
    output logic [DATA-1:0] mul_y,
    output logic            mul_valid,
    input  logic            mul_ready,
    input  logic [DATA-1:0] mul_res,
    input  logic            mul_res_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    // Last READ cycle index; the counter only has to cover RD_LAT of 1..3.
    localparam logic [1:0] RD_LAST = 2'(RD_LAT - 1);

    state_t          r_state;
    logic [ADDR-1:0] r_adbus_a;
    logic [ADDR-1:0] r_adbus_b;
    logic [ADDR-1:0] r_dst;
    logic [1:0]      r_rd_cnt;
    logic [DATA-1:0] r_mul_x;
    logic [DATA-1:0] r_mul_y;
    logic            r_mul_valid;
    logic            r_w_c;
    logic [ADDR-1:0] r_adbus_c;
    logic [DATA-1:0] r_data_in_c;
    logic            r_busy;
    logic            r_done;

`ifdef MUL_SEQ_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic            r_err;
    logic [TO_W-1:0] r_to_cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_adbus_a   <= '0;
            r_adbus_b   <= '0;
            r_dst       <= '0;
            r_rd_cnt    <= '0;
            r_mul_x     <= '0;
            r_mul_y     <= '0;
            r_mul_valid <= 1'b0;
            r_w_c       <= 1'b0;
            r_adbus_c   <= '0;
            r_data_in_c <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef MUL_SEQ_TIMEOUT_EN
            r_err       <= 1'b0;
            r_to_cnt    <= '0;
`endif
        end else begin
            // NOTE: non-blocking defaults here make b_w_C, b_data_in_C and done single-cycle
            // pulses; any branch below that asserts them overrides the default for that edge.
            r_w_c       <= 1'b0;
            r_data_in_c <= '0;
            r_done      <= 1'b0;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_adbus_a <= src_x_addr;
                        r_adbus_b <= src_y_addr;
                        r_dst     <= dst_addr;
                        r_rd_cnt  <= '0;
                        r_busy    <= 1'b1;
`ifdef MUL_SEQ_TIMEOUT_EN
                        r_err     <= 1'b0;
`endif
                        r_state   <= S_READ;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_READ: begin
                    if (r_rd_cnt == RD_LAST) begin
                        r_mul_x     <= b_data_out_A;
                        r_mul_y     <= b_data_out_B;
                        r_mul_valid <= 1'b1;
                        r_state     <= S_ISSUE;
                    end else begin
                        r_rd_cnt <= r_rd_cnt + 2'd1;
                    end
                end

                S_ISSUE: begin
                    // mul_valid is high for the whole of ISSUE, so ready alone marks the transfer.
                    if (mul_ready) begin
                        r_mul_valid <= 1'b0;
`ifdef MUL_SEQ_TIMEOUT_EN
                        r_to_cnt    <= '0;
`endif
                        r_state     <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (mul_res_valid) begin
                        r_w_c       <= 1'b1;
                        r_adbus_c   <= r_dst;
                        r_data_in_c <= mul_res;
                        r_state     <= S_WRITE;
                    end
`ifdef MUL_SEQ_TIMEOUT_EN
                    else if (r_to_cnt == TO_LAST) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end

                S_WRITE: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign b_w_A       = 1'b0;
    assign b_w_B       = 1'b0;
    assign b_adbus_A   = r_adbus_a;
    assign b_adbus_B   = r_adbus_b;
    assign b_data_in_A = '0;
    assign b_data_in_B = '0;
    assign b_w_C       = r_w_c;
    assign b_adbus_C   = r_adbus_c;
    assign b_data_in_C = r_data_in_c;
    assign mul_x       = r_mul_x;
    assign mul_y       = r_mul_y;
    assign mul_valid   = r_mul_valid;

`ifdef MUL_SEQ_TIMEOUT_EN
    assign err = r_err;
`else
    // Without the timeout WAIT never gives up, so TIMEOUT_CYC has no hardware behind it.
    logic w_timeout_unused;
    assign w_timeout_unused = (TIMEOUT_CYC != 0);
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Scoreboard bench for mul_operand_sequencer: instance 0 uses RD_LAT=1, instance 1 RD_LAT=3,
// with behavioural banks A/B and a multiplier model of programmable product delay.
module tb_mul_operand_sequencer;

    localparam int DATA = 256;
    localparam int ADDR = 2;
    localparam int NI   = 2;

    typedef logic [DATA-1:0] word_t;
    typedef struct {
        int              inst;
        logic [ADDR-1:0] addr;
        word_t           data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            start_s  [NI];
    logic [ADDR-1:0] sx_s     [NI];
    logic [ADDR-1:0] sy_s     [NI];
    logic [ADDR-1:0] dst_s    [NI];
    logic            busy_s   [NI];
    logic            done_s   [NI];
    logic            err_s    [NI];
    logic            w_a_s    [NI];
    logic            w_b_s    [NI];
    logic            w_c_s    [NI];
    logic [ADDR-1:0] ad_a_s   [NI];
    logic [ADDR-1:0] ad_b_s   [NI];
    logic [ADDR-1:0] ad_c_s   [NI];
    word_t           din_a_s  [NI];
    word_t           din_b_s  [NI];
    word_t           dout_a_s [NI];
    word_t           dout_b_s [NI];
    word_t           din_c_s  [NI];
    word_t           mx_s     [NI];
    word_t           my_s     [NI];
    word_t           mres_s   [NI];
    logic            mvalid_s [NI];
    logic            mready_s [NI];
    logic            mres_v_s [NI];
    int              res_delay_s [NI];

    word_t mem_a [NI][4];
    word_t mem_b [NI][4];

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;

        logic [ADDR-1:0] pa [2];
        logic [ADDR-1:0] pb [2];
        int              rcnt;
        logic            armed;
        word_t           prod;

        mul_operand_sequencer #(
            .DATA(DATA), .ADDR(ADDR), .RD_LAT(LAT), .TIMEOUT_CYC(10)
        ) u_dut (
            .clk(clk), .rst(rst), .start(start_s[g]),
            .src_x_addr(sx_s[g]), .src_y_addr(sy_s[g]), .dst_addr(dst_s[g]),
            .busy(busy_s[g]), .done(done_s[g]), .err(err_s[g]),
            .b_w_A(w_a_s[g]), .b_w_B(w_b_s[g]),
            .b_adbus_A(ad_a_s[g]), .b_adbus_B(ad_b_s[g]),
            .b_data_in_A(din_a_s[g]), .b_data_in_B(din_b_s[g]),
            .b_data_out_A(dout_a_s[g]), .b_data_out_B(dout_b_s[g]),
            .b_w_C(w_c_s[g]), .b_adbus_C(ad_c_s[g]), .b_data_in_C(din_c_s[g]),
            .mul_x(mx_s[g]), .mul_y(my_s[g]), .mul_valid(mvalid_s[g]),
            .mul_ready(mready_s[g]), .mul_res(mres_s[g]), .mul_res_valid(mres_v_s[g])
        );

        // Bank read data lags the address by RD_LAT-1 extra register stages.
        always @(posedge clk) begin
            pa[0] <= ad_a_s[g];
            pa[1] <= pa[0];
            pb[0] <= ad_b_s[g];
            pb[1] <= pb[0];
        end
        assign dout_a_s[g] = mem_a[g][(LAT == 1) ? ad_a_s[g] : pa[1]];
        assign dout_b_s[g] = mem_b[g][(LAT == 1) ? ad_b_s[g] : pb[1]];

        // Product appears res_delay cycles after the first WAIT cycle; negative means never.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                armed <= 1'b0;
                rcnt  <= 0;
                prod  <= '0;
            end else if (mvalid_s[g] && mready_s[g]) begin
                prod  <= mx_s[g] * my_s[g];
                rcnt  <= res_delay_s[g];
                armed <= (res_delay_s[g] >= 0);
            end else if (armed) begin
                if (rcnt == 0) armed <= 1'b0;
                else           rcnt  <= rcnt - 1;
            end
        end
        assign mres_v_s[g] = armed && (rcnt == 0);
        assign mres_s[g]   = prod;
    end

    // Scoreboard and bus-quiet monitor.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < NI; i++) begin
            if (w_c_s[i]) begin
                if (exp_q.size() == 0) begin
                    check("sb_extra_write", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_inst", i, e.inst);
                    check("sb_addr", ad_c_s[i], e.addr);
                    check("sb_data", din_c_s[i], e.data);
                end
            end else if (din_c_s[i] != '0) begin
                check("din_c_idle", din_c_s[i], 0);
            end
            if (w_a_s[i] || w_b_s[i]) check("bank_ab_we", {w_a_s[i], w_b_s[i]}, 0);
            if ((din_a_s[i] | din_b_s[i]) != '0) check("bank_ab_din", din_a_s[i] | din_b_s[i], 0);
        end
    end

    task automatic run_cmd(input string name, input int i,
                           input logic [ADDR-1:0] x, input logic [ADDR-1:0] y,
                           input logic [ADDR-1:0] d, input int stall, input int rdelay,
                           input int poke, input int exp_valid, input int exp_write,
                           input int exp_done, input logic exp_err);
        int    first_valid = -1;
        int    first_write = -1;
        int    first_done  = -1;
        int    n_valid     = 0;
        int    n_write     = 0;
        logic  busy_bad    = 1'b0;
        logic  xy_moved    = 1'b0;
        logic  done_err    = 1'b0;
        word_t x0          = '0;
        word_t y0          = '0;

        @(negedge clk);
        check({name, "_pre_done"}, done_s[i], 0);
        res_delay_s[i] = rdelay;
        mready_s[i]    = (stall == 0);
        start_s[i]     = 1'b1;
        sx_s[i]        = x;
        sy_s[i]        = y;
        dst_s[i]       = d;
        if (exp_write >= 0) exp_q.push_back('{i, d, mem_a[i][x] * mem_b[i][y]});

        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            start_s[i] = (k == poke);
            if (k == poke) begin
                sx_s[i]  = ~x;
                sy_s[i]  = ~y;
                dst_s[i] = ~d;
            end
            if (mvalid_s[i]) begin
                n_valid++;
                if (first_valid < 0) begin
                    first_valid = k;
                    x0 = mx_s[i];
                    y0 = my_s[i];
                end else if (mx_s[i] !== x0 || my_s[i] !== y0) begin
                    xy_moved = 1'b1;
                end
                if (n_valid > stall) mready_s[i] = 1'b1;
            end
            if (w_c_s[i]) begin
                n_write++;
                if (first_write < 0) first_write = k;
            end
            if (done_s[i]) begin
                first_done = k;
                done_err   = err_s[i];
                if (busy_s[i]) busy_bad = 1'b1;
                break;
            end else if (!busy_s[i]) begin
                busy_bad = 1'b1;
            end
        end
        start_s[i] = 1'b0;

        check({name, "_valid_cyc"}, first_valid, exp_valid);
        check({name, "_write_cyc"}, first_write, exp_write);
        check({name, "_write_cnt"}, n_write, (exp_write >= 0) ? 1 : 0);
        check({name, "_done_cyc"}, first_done, exp_done);
        check({name, "_busy"}, busy_bad, 0);
        check({name, "_xy_stable"}, xy_moved, 0);
        check({name, "_mul_x"}, x0, mem_a[i][x]);
        check({name, "_mul_y"}, y0, mem_b[i][y]);
        check({name, "_err"}, done_err, exp_err);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            start_s[i]     = 1'b0;
            sx_s[i]        = '0;
            sy_s[i]        = '0;
            dst_s[i]       = '0;
            mready_s[i]    = 1'b0;
            res_delay_s[i] = 0;
            for (int j = 0; j < 4; j++) begin
                mem_a[i][j] = word_t'(32'h100 + 16 * i + j);
                mem_b[i][j] = word_t'(32'h200 + 16 * i + j);
            end
        end
        mem_a[0][1] = word_t'(8'h5);
        mem_b[0][2] = word_t'(8'h7);
        mem_a[0][3] = {8{32'hdeadbeef}};
        mem_b[0][3] = {8{32'h13572468}};
        mem_a[1][1] = word_t'(8'h11);
        mem_b[1][2] = word_t'(8'h22);
        mem_a[1][0] = word_t'(8'hA);
        mem_b[1][0] = word_t'(8'hB);

        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("rst_ctrl", {busy_s[i], done_s[i], err_s[i], w_c_s[i], mvalid_s[i]}, 0);
            check("rst_addr", {ad_a_s[i], ad_b_s[i], ad_c_s[i]}, 0);
            check("rst_data", din_c_s[i] | mx_s[i] | my_s[i], 0);
        end
        rst = 1'b0;

        run_cmd("t1", 0, 2'd1, 2'd2, 2'd3, 0, 0, -1, 2, 4, 5, 1'b0);
        check("t1_product", mem_a[0][1] * mem_b[0][2], word_t'(8'h23));
        run_cmd("wide", 0, 2'd3, 2'd3, 2'd0, 0, 1, -1, 2, 5, 6, 1'b0);
        run_cmd("t2", 0, 2'd1, 2'd2, 2'd1, 6, 0, -1, 2, 10, 11, 1'b0);
        run_cmd("t3", 0, 2'd0, 2'd2, 2'd2, 0, 3, 4, 2, 7, 8, 1'b0);
        run_cmd("t4_warm", 1, 2'd1, 2'd2, 2'd1, 0, 0, -1, 4, 6, 7, 1'b0);
        run_cmd("t4", 1, 2'd0, 2'd0, 2'd2, 0, 0, -1, 4, 6, 7, 1'b0);

        // Reset lands in the middle of the WRITE cycle.
        @(negedge clk);
        start_s[0]     = 1'b1;
        sx_s[0]        = 2'd1;
        sy_s[0]        = 2'd2;
        dst_s[0]       = 2'd0;
        mready_s[0]    = 1'b1;
        res_delay_s[0] = 0;
        exp_q.push_back('{0, 2'd0, mem_a[0][1] * mem_b[0][2]});
        @(negedge clk);
        start_s[0] = 1'b0;
        for (int k = 0; k < 20 && !w_c_s[0]; k++) @(negedge clk);
        check("t5_write_seen", w_c_s[0], 1);
        #1 rst = 1'b1;
        #1;
        check("t5_rst_wc", w_c_s[0], 0);
        check("t5_rst_ctrl", {busy_s[0], done_s[0], err_s[0], mvalid_s[0]}, 0);
        check("t5_rst_bus", {ad_a_s[0], ad_b_s[0], ad_c_s[0]}, 0);
        check("t5_rst_data", din_c_s[0] | mx_s[0] | my_s[0], 0);
        @(negedge clk);
        rst = 1'b0;
        run_cmd("t5_after", 0, 2'd1, 2'd2, 2'd3, 0, 0, -1, 2, 4, 5, 1'b0);

`ifdef MUL_SEQ_TIMEOUT_EN
        run_cmd("t6", 0, 2'd1, 2'd2, 2'd2, 0, -1, -1, 2, -1, 13, 1'b1);
        @(negedge clk);
        check("t6_err_sticky", err_s[0], 1);
        run_cmd("t6_clear", 0, 2'd2, 2'd0, 2'd1, 0, 0, -1, 2, 4, 5, 1'b0);
`endif

        repeat (2) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
